// File: rtl/md_sched_if.sv
// Handshake/result bundle between the ID/EX issue logic and the HI/LO
// multiply/divide sequencer.
interface md_sched_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        md_instr_id;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, cancel, md_instr_id,
        input  busy, stall_req, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, cancel, md_instr_id,
        output busy, stall_req, done, hi, lo
    );
endinterface

// File: rtl/md_sched.sv
// HI/LO multiply/divide sequencer: models mult/div latency, commits HI/LO, stalls ID.
// Optional macro MD_CANCEL_RUN_EN: a cancel while busy aborts the in-flight op.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  md
);

    localparam int MAX_N = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W = $clog2(MAX_N + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               done_r, done_n;
    logic [31:0]        hi_r, lo_r, hi_n, lo_n;
    logic [63:0]        pend_p0, pend_n;
    logic               dz_p0, dz_n;
    logic               accept;

    function automatic logic [63:0] mul64(input logic is_signed,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = is_signed ? {{32{a[31]}}, a} : {32'h0, a};
        eb = is_signed ? {{32{b[31]}}, b} : {32'h0, b};
        mul64 = ea * eb;
    endfunction

    // Returns {remainder, quotient}; the overflow case is pinned explicitly.
    function automatic logic [63:0] div64(input logic is_signed,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa = a;
        sb = b;
        div64 = 64'h0;
        if (b == 32'h0) begin
            div64 = 64'h0;
        end else if (is_signed) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                div64 = {32'h0, 32'h8000_0000};
            end else begin
                q = sa / sb;
                r = sa % sb;
                div64 = {r, q};
            end
        end else begin
            div64 = {a % b, a / b};
        end
    endfunction

    assign accept = md.start & ~md.cancel & (state == IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        hi_n    = hi_r;
        lo_n    = lo_r;
        pend_n  = pend_p0;
        dz_n    = dz_p0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (md.op)
                        3'd0, 3'd1: begin
                            state_n = RUN;
                            cnt_n   = CNT_W'(MULT_CYCLES - 1);
                            pend_n  = mul64(md.op == 3'd0, md.src_a, md.src_b);
                            dz_n    = 1'b0;
                        end
                        3'd2, 3'd3: begin
                            state_n = RUN;
                            cnt_n   = CNT_W'(DIV_CYCLES - 1);
                            pend_n  = div64(md.op == 3'd2, md.src_a, md.src_b);
                            dz_n    = (md.src_b == 32'h0);
                        end
                        3'd4:    hi_n = md.src_a;
                        3'd5:    lo_n = md.src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    if (!dz_p0) begin
                        hi_n = pend_p0[63:32];
                        lo_n = pend_p0[31:0];
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
`ifdef MD_CANCEL_RUN_EN
                if (md.cancel) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b0;
                    hi_n    = hi_r;
                    lo_n    = lo_r;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done_r <= 1'b0;
            hi_r   <= 32'h0;
            lo_r   <= 32'h0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            done_r <= done_n;
            hi_r   <= hi_n;
            lo_r   <= lo_n;
        end
    end

    // Pending result is data only; its validity is carried by state.
    always_ff @(posedge clk) begin
        pend_p0 <= pend_n;
        dz_p0   <= dz_n;
    end

    assign md.busy      = (state == RUN);
    assign md.done      = done_r;
    assign md.hi        = hi_r;
    assign md.lo        = lo_r;
    assign md.stall_req = md.md_instr_id &
                          (md.busy | (md.start & ~md.cancel & (md.op <= 3'd3)));

endmodule

// File: tb/tb_md_sched.sv
// Directed-vector bench for md_sched (HI/LO multiply/divide sequencer).
module tb_md_sched;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_bad = 0;

    md_sched_if md();

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div op, track busy length and stall, then check the commit.
    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic id, input int n_exp,
                          input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        int n;
        md.md_instr_id = id;
        md.op          = op;
        md.src_a       = a;
        md.src_b       = b;
        md.cancel      = 1'b0;
        md.start       = 1'b1;
        #1;
        chk({tag, "/stall_issue"}, md.stall_req, id);
        step();
        md.start = 1'b0;
        n = 0;
        while (md.busy && n < 40) begin
            n++;
            chk({tag, "/stall_busy"}, md.stall_req, id);
            chk({tag, "/done_early"}, md.done, 1'b0);
            step();
        end
        chk({tag, "/busy_cycles"}, n, n_exp);
        chk({tag, "/done"}, md.done, 1'b1);
        chk({tag, "/stall_after"}, md.stall_req, 1'b0);
        chk({tag, "/hi"}, md.hi, hi_exp);
        chk({tag, "/lo"}, md.lo, lo_exp);
        md.md_instr_id = 1'b0;
        step();
        chk({tag, "/done_1cyc"}, md.done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        md.start       = 1'b0;
        md.op          = 3'd0;
        md.src_a       = 32'h0;
        md.src_b       = 32'h0;
        md.cancel      = 1'b0;
        md.md_instr_id = 1'b1;
        reset          = 1'b0;
        step();
        step();
        chk("rst/hi", md.hi, 32'h0);
        chk("rst/lo", md.lo, 32'h0);
        chk("rst/busy", md.busy, 1'b0);
        chk("rst/done", md.done, 1'b0);
        chk("rst/stall", md.stall_req, 1'b0);
        reset = 1'b1;
        step();

        // -1 * 2 signed; 0xFFFFFFFF * 2 unsigned
        run_md("mult",  3'd0, 32'hFFFF_FFFF, 32'h2, 1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_md("multu", 3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, 5,  32'h0000_0001, 32'hFFFF_FFFE);
        // -7/2 -> q=-3 r=-1
        run_md("div",   3'd2, 32'hFFFF_FFF9, 32'h2, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        // divide by zero leaves HI/LO untouched
        run_md("divu0", 3'd3, 32'h7,         32'h0, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        // 7 / -2 -> q=-3 r=1
        run_md("divneg", 3'd2, 32'h7,        32'hFFFF_FFFE, 1'b0, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_md("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'h0, 32'h8000_0000);
        // 0xFFFFFFF9 / 2 unsigned -> q=0x7FFFFFFC r=1
        run_md("divu",  3'd3, 32'hFFFF_FFF9, 32'h2, 1'b0, 10, 32'h0000_0001, 32'h7FFF_FFFC);

        // mtlo with cancel is discarded, then accepted
        md.start  = 1'b1;
        md.op     = 3'd5;
        md.src_a  = 32'h1234;
        md.cancel = 1'b1;
        step();
        md.start  = 1'b0;
        md.cancel = 1'b0;
        chk("mtlo_cxl/lo", md.lo, 32'h7FFF_FFFC);
        chk("mtlo_cxl/busy", md.busy, 1'b0);
        md.start = 1'b1;
        step();
        md.start = 1'b0;
        chk("mtlo/lo", md.lo, 32'h1234);
        chk("mtlo/busy", md.busy, 1'b0);
        chk("mtlo/done", md.done, 1'b0);
        md.start = 1'b1;
        md.op    = 3'd4;
        md.src_a = 32'h5678;
        step();
        md.start = 1'b0;
        chk("mthi/hi", md.hi, 32'h5678);
        chk("mthi/busy", md.busy, 1'b0);
        step();
        chk("mthi/done", md.done, 1'b0);

        // start & cancel on a mult: no stall, no busy
        md.md_instr_id = 1'b1;
        md.start       = 1'b1;
        md.op          = 3'd0;
        md.src_a       = 32'h3;
        md.src_b       = 32'h4;
        md.cancel      = 1'b1;
        #1;
        chk("mult_cxl/stall", md.stall_req, 1'b0);
        step();
        md.start       = 1'b0;
        md.cancel      = 1'b0;
        md.md_instr_id = 1'b0;
        chk("mult_cxl/busy", md.busy, 1'b0);
        step();
        chk("mult_cxl/done", md.done, 1'b0);
        chk("mult_cxl/lo", md.lo, 32'h1234);

        // reserved op
        md.start = 1'b1;
        md.op    = 3'd6;
        md.src_a = 32'hDEAD;
        step();
        md.start = 1'b0;
        chk("rsvd/hi", md.hi, 32'h5678);
        chk("rsvd/lo", md.lo, 32'h1234);
        chk("rsvd/busy", md.busy, 1'b0);

        // div 100/7 with cancel in the third busy cycle
        md.start = 1'b1;
        md.op    = 3'd2;
        md.src_a = 32'd100;
        md.src_b = 32'd7;
        step();
        md.start = 1'b0;
        n = 0;
        while (md.busy && n < 40) begin
            n++;
            md.cancel = (n == 3);
            step();
        end
        md.cancel = 1'b0;
`ifdef MD_CANCEL_RUN_EN
        chk("div_cxl/busy_cycles", n, 3);
        chk("div_cxl/done", md.done, 1'b0);
        chk("div_cxl/hi", md.hi, 32'h5678);
        chk("div_cxl/lo", md.lo, 32'h1234);
`else
        chk("div_cxl/busy_cycles", n, 10);
        chk("div_cxl/done", md.done, 1'b1);
        chk("div_cxl/hi", md.hi, 32'd2);
        chk("div_cxl/lo", md.lo, 32'd14);
`endif
        step();
        chk("div_cxl/done_after", md.done, 1'b0);

        // reset in the middle of a mult
        md.start = 1'b1;
        md.op    = 3'd0;
        md.src_a = 32'h3;
        md.src_b = 32'h4;
        step();
        md.start = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_mid/busy", md.busy, 1'b0);
        chk("rst_mid/hi", md.hi, 32'h0);
        chk("rst_mid/lo", md.lo, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_mid/no_done", md.done, 1'b0);
        end
        chk("rst_mid/lo_kept", md.lo, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
